// File: rtl/ddr3_ui_responder_if.sv
// MIG-style UI command / write-data / read-data bundle between the initiator
// (master) and the BRAM-backed responder (slave).
interface ddr3_ui_responder_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
);
    logic                    app_en;
    logic [2:0]              app_cmd;
    logic [ADDR_WIDTH-1:0]   app_addr;
    logic                    app_rdy;
    logic                    app_wdf_wren;
    logic [DATA_WIDTH-1:0]   app_wdf_data;
    logic                    app_wdf_end;
    logic [DATA_WIDTH/8-1:0] app_wdf_mask;
    logic                    app_wdf_rdy;
    logic [DATA_WIDTH-1:0]   app_rd_data;
    logic                    app_rd_data_valid;
    logic                    app_rd_data_end;

    modport master (
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/ddr3_ui_responder.sv
// BRAM-backed stand-in for the MIG DDR3 UI: one 128-bit beat per command, fixed read latency.
// Optional macro UI_BACKPRESSURE_EN adds LFSR-driven random deassertion of app_rdy / app_wdf_rdy.
module ddr3_ui_responder #(
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 128,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int RD_LATENCY     = 4,
    parameter int WDF_DEPTH_LOG2 = 2,
    parameter int CALIB_CYCLES   = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 calib_done,
    output logic                 protocol_err,
    ddr3_ui_responder_if.slave   ui
);
    localparam int unsigned MASK_W    = DATA_WIDTH / 8;
    localparam int unsigned WDF_DEPTH = 1 << WDF_DEPTH_LOG2;
    localparam int unsigned MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int          CAL_W     = $clog2(CALIB_CYCLES + 1);
    localparam logic [2:0]  CMD_WR    = 3'b000;
    localparam logic [2:0]  CMD_RD    = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_e;

    state_e state_q, state_d;
    logic [CAL_W-1:0] cal_cnt_q;
    logic calib_q, err_q;
    logic bp_cmd_ok, bp_wdf_ok;
    logic retire, drop, mem_we, wdf_pop, rd_issue;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
        end else if (!calib_q) begin
            cal_cnt_q <= cal_cnt_q + 1'b1;
            if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
        end
    end
    assign calib_done = calib_q;

`ifdef UI_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (!reset_n)     lfsr_q <= 16'hACE1;
        else if (calib_q) lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
    assign bp_cmd_ok = (lfsr_q[1:0] != 2'b00);
    assign bp_wdf_ok = (lfsr_q[3:2] != 2'b00);
`else
    assign bp_cmd_ok = 1'b1;
    assign bp_wdf_ok = 1'b1;
`endif

    // Write-data FIFO; pointers carry an extra wrap bit to tell full from empty.
    logic [DATA_WIDTH-1:0]   wdf_data_q [WDF_DEPTH];
    logic [MASK_W-1:0]       wdf_mask_q [WDF_DEPTH];
    logic [WDF_DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
    logic [WDF_DEPTH_LOG2-1:0] wdf_rd_idx;
    logic wdf_empty, wdf_full, wdf_push;

    assign wdf_rd_idx = rd_ptr_q[WDF_DEPTH_LOG2-1:0];
    assign wdf_empty  = (wr_ptr_q == rd_ptr_q);
    assign wdf_full   = (wr_ptr_q[WDF_DEPTH_LOG2] != rd_ptr_q[WDF_DEPTH_LOG2]) &&
                        (wr_ptr_q[WDF_DEPTH_LOG2-1:0] == rd_ptr_q[WDF_DEPTH_LOG2-1:0]);
    assign ui.app_wdf_rdy = calib_q & ~wdf_full & bp_wdf_ok;
    assign wdf_push       = ui.app_wdf_wren & ui.app_wdf_rdy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wdf_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (wdf_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wdf_push) begin
            wdf_data_q[wr_ptr_q[WDF_DEPTH_LOG2-1:0]] <= ui.app_wdf_data;
            wdf_mask_q[wr_ptr_q[WDF_DEPTH_LOG2-1:0]] <= ui.app_wdf_mask;
        end
    end

    // Command slot: a retiring slot counts as free so accept and retire can share a cycle.
    logic                      slot_full_q;
    logic [2:0]                slot_cmd_q;
    logic [MEM_DEPTH_LOG2-1:0] slot_idx_q;
    logic                      cmd_acc;

    assign ui.app_rdy = calib_q & (~slot_full_q | retire) & bp_cmd_ok;
    assign cmd_acc    = ui.app_en & ui.app_rdy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_full_q <= 1'b0;
            slot_cmd_q  <= '0;
            slot_idx_q  <= '0;
        end else if (cmd_acc) begin
            slot_full_q <= 1'b1;
            slot_cmd_q  <= ui.app_cmd;
            slot_idx_q  <= ui.app_addr[2+MEM_DEPTH_LOG2:3];
        end else if (retire) begin
            slot_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (slot_full_q) begin
                if (slot_cmd_q == CMD_WR)      state_d = S_WR;
                else if (slot_cmd_q == CMD_RD) state_d = S_RD;
            end
            S_WR:    if (!wdf_empty) state_d = S_IDLE;
            S_RD:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        retire   = 1'b0;
        drop     = 1'b0;
        mem_we   = 1'b0;
        wdf_pop  = 1'b0;
        rd_issue = 1'b0;
        case (state_q)
            S_IDLE: begin
                drop   = slot_full_q & (slot_cmd_q != CMD_WR) & (slot_cmd_q != CMD_RD);
                retire = drop;
            end
            S_WR: if (!wdf_empty) begin
                mem_we  = 1'b1;
                wdf_pop = 1'b1;
                retire  = 1'b1;
            end
            S_RD: begin
                rd_issue = 1'b1;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    // BRAM has no reset: contents survive reset_n.
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    always_ff @(posedge clk) begin
        if (mem_we && reset_n) begin
            for (int unsigned b = 0; b < MASK_W; b++) begin
                if (!wdf_mask_q[wdf_rd_idx][b])
                    mem_q[slot_idx_q][8*b +: 8] <= wdf_data_q[wdf_rd_idx][8*b +: 8];
            end
        end
    end

    logic [RD_LATENCY-1:0] rd_vld_q;
    logic [DATA_WIDTH-1:0] rd_dat_q [RD_LATENCY];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_vld_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) rd_dat_q[i] <= '0;
        end else begin
            rd_vld_q[0] <= rd_issue;
            rd_dat_q[0] <= rd_issue ? mem_q[slot_idx_q] : '0;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_dat_q[i] <= rd_dat_q[i-1];
            end
        end
    end
    assign ui.app_rd_data       = rd_dat_q[RD_LATENCY-1];
    assign ui.app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
    assign ui.app_rd_data_end   = rd_vld_q[RD_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!reset_n) err_q <= 1'b0;
        else if (drop || (cmd_acc && (ui.app_addr[2:0] != 3'b000)) || (wdf_push && !ui.app_wdf_end))
            err_q <= 1'b1;
    end
    assign protocol_err = err_q;

    // Upper address bits alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ui.app_addr[ADDR_WIDTH-1:3+MEM_DEPTH_LOG2];
endmodule

// File: tb/tb_ddr3_ui_responder.sv
// Scoreboard bench for ddr3_ui_responder: array/queue memory model, directed cases then random traffic.
module tb_ddr3_ui_responder;
    localparam int AW = 28, DW = 128, MW = 16, MDL = 10, RDL = 4, CAL = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic calib_done, protocol_err;

    ddr3_ui_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ui();

    ddr3_ui_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(MDL),
        .RD_LATENCY(RDL), .WDF_DEPTH_LOG2(2), .CALIB_CYCLES(CAL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
        .protocol_err(protocol_err), .ui(ui)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0, checks = 0;

    typedef struct { logic [DW-1:0] d; int t; } exp_t;
    exp_t sb[$];
    logic [DW-1:0] mdl [int];
    int pend_idx[$];
    logic [DW+MW-1:0] pend_beat[$];

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name, string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Writes retire in order, so the n-th write command takes the n-th accepted beat.
    function automatic void apply_writes();
        while (pend_idx.size() > 0 && pend_beat.size() > 0) begin
            int i;
            logic [DW+MW-1:0] b;
            logic [DW-1:0] cur;
            i = pend_idx.pop_front();
            b = pend_beat.pop_front();
            cur = mdl.exists(i) ? mdl[i] : '0;
            for (int k = 0; k < MW; k++)
                if (!b[DW+k]) cur[8*k +: 8] = b[8*k +: 8];
            mdl[i] = cur;
        end
    endfunction

    always @(negedge clk) begin
        if (ui.app_rd_data_valid === 1'b1) begin
            chk("rd_end", DW'(ui.app_rd_data_end), DW'(1));
            if (sb.size() == 0) begin
                fail_now("unexpected_rd", "got valid=1 expected no read outstanding");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", ui.app_rd_data, e.d);
                chk("rd_latency", DW'(cyc), DW'(e.t));
            end
        end
    end

    task automatic push_beat(input logic [DW-1:0] d, input logic [MW-1:0] m);
        int t;
        t = 0;
        ui.app_wdf_data = d;
        ui.app_wdf_mask = m;
        ui.app_wdf_end  = 1'b1;
        ui.app_wdf_wren = 1'b1;
        while (ui.app_wdf_rdy !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) fail_now("wdf_timeout", "got app_wdf_rdy=0 for 300 cycles expected 1");
        else begin
            pend_beat.push_back({m, d});
            apply_writes();
        end
        @(negedge clk);
        ui.app_wdf_wren = 1'b0;
    endtask

    task automatic issue_cmd(input logic [2:0] c, input logic [AW-1:0] a);
        int t;
        t = 0;
        ui.app_cmd  = c;
        ui.app_addr = a;
        ui.app_en   = 1'b1;
        while (ui.app_rdy !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) fail_now("cmd_timeout", "got app_rdy=0 for 300 cycles expected 1");
        else begin
            int i;
            i = int'(a[MDL+2:3]);
            if (c == 3'b000) begin
                pend_idx.push_back(i);
                apply_writes();
            end else if (c == 3'b001) begin
                exp_t e;
                e.d = mdl.exists(i) ? mdl[i] : 'x;
                e.t = cyc + 1 + RDL + 1;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        ui.app_en = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m,
                         input bit data_first);
        if (data_first) begin push_beat(d, m); issue_cmd(3'b000, a); end
        else begin issue_cmd(3'b000, a); push_beat(d, m); end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 300) begin @(negedge clk); t++; end
        if (sb.size() > 0) fail_now("drain_timeout", "got reads outstanding expected none");
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        ui.app_en = 1'b0;
        ui.app_wdf_wren = 1'b0;
        sb.delete();
        pend_idx.delete();
        pend_beat.delete();
        repeat (3) @(negedge clk);
        chk("rst_calib", DW'(calib_done), '0);
        chk("rst_app_rdy", DW'(ui.app_rdy), '0);
        chk("rst_wdf_rdy", DW'(ui.app_wdf_rdy), '0);
        chk("rst_valid", DW'(ui.app_rd_data_valid), '0);
        chk("rst_end", DW'(ui.app_rd_data_end), '0);
        chk("rst_rd_data", ui.app_rd_data, '0);
        chk("rst_err", DW'(protocol_err), '0);
        reset_n = 1'b1;
    endtask

    task automatic wait_calib();
        int n;
        bit rdy_seen;
        n = 0;
        rdy_seen = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (calib_done === 1'b1) break;
            if (ui.app_rdy !== 1'b0 || ui.app_wdf_rdy !== 1'b0) rdy_seen = 1;
        end
        chk("calib_edges", DW'(n), DW'(CAL));
        chk("rdy_before_calib", DW'(rdy_seen), '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] beats [4];
        int pool [8];

        ui.app_en = 1'b0; ui.app_cmd = '0; ui.app_addr = '0;
        ui.app_wdf_wren = 1'b0; ui.app_wdf_data = '0; ui.app_wdf_end = 1'b0; ui.app_wdf_mask = '0;

        do_reset();
        wait_calib();

        // Basic write then read
        write(28'h10, 128'h0123456789ABCDEF0123456789ABCDEF, '0, 1);
        issue_cmd(3'b001, 28'h10);
        drain();

        // Byte mask: lower 8 bytes keep old all-FF value
        write(28'h0, '1, '0, 1);
        write(28'h0, '0, 16'h00FF, 0);
        issue_cmd(3'b001, 28'h0);
        drain();

        // Fill FIFO with 4 beats, 5th ignored, then 4 commands drain it in order
        for (int k = 0; k < 4; k++) begin
            beats[k] = {$urandom, $urandom, $urandom, $urandom};
            push_beat(beats[k], '0);
        end
        chk("wdf_full_rdy", DW'(ui.app_wdf_rdy), '0);
        ui.app_wdf_data = '1;
        ui.app_wdf_mask = '0;
        ui.app_wdf_wren = 1'b1;
        repeat (3) @(negedge clk);
        chk("wdf_still_full", DW'(ui.app_wdf_rdy), '0);
        ui.app_wdf_wren = 1'b0;
        for (int k = 0; k < 4; k++) issue_cmd(3'b000, AW'(28'h40 + 8 * k));
        for (int k = 0; k < 4; k++) issue_cmd(3'b001, AW'(28'h40 + 8 * k));
        drain();
        chk("wdf_empty_rdy", DW'(ui.app_wdf_rdy), DW'(1));

        // Aliasing and misaligned address
        d = {$urandom, $urandom, $urandom, $urandom};
        write(28'h2000, d, '0, 0);
        issue_cmd(3'b001, 28'h0);
        drain();
        chk("err_clean", DW'(protocol_err), '0);
        issue_cmd(3'b001, 28'h3);
        drain();
        chk("err_misaligned", DW'(protocol_err), DW'(1));

        // Reset with a read in flight; BRAM survives
        issue_cmd(3'b001, 28'h10);
        repeat (2) @(negedge clk);
        do_reset();
        wait_calib();
        issue_cmd(3'b001, 28'h10);
        issue_cmd(3'b001, 28'h2000);
        drain();

        // Illegal command is dropped and flagged
        chk("err_after_reset", DW'(protocol_err), '0);
        issue_cmd(3'b010, 28'h8);
        drain();
        chk("err_illegal", DW'(protocol_err), DW'(1));
        issue_cmd(3'b001, 28'h48);
        drain();

        // Random traffic over a small pool of indices with aliased upper bits
        do_reset();
        wait_calib();
        for (int k = 0; k < 8; k++) begin
            pool[k] = $urandom_range(0, (1 << MDL) - 1);
            write(AW'(pool[k] << 3), {$urandom, $urandom, $urandom, $urandom}, '0, $urandom_range(0, 1) == 1);
        end
        for (int n = 0; n < 250; n++) begin
            int k;
            logic [AW-1:0] a;
            k = $urandom_range(0, 7);
            a = AW'(($urandom_range(0, 3) << (MDL + 3)) | (pool[k] << 3));
            if ($urandom_range(0, 1) == 1)
                write(a, {$urandom, $urandom, $urandom, $urandom}, MW'($urandom), $urandom_range(0, 1) == 1);
            else
                issue_cmd(3'b001, a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        chk("rand_err", DW'(protocol_err), '0);
        chk("sb_empty", DW'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
